uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OSR, default 16, giving oversample ticks per bit (even, >=8).
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame (5..8).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable_i, input, 1, receiver enable.
REQ-006 SHALL have port osr_tick_i, input, 1, single-cycle oversample strobe from the oversample tick generator.
REQ-007 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port parity_en_i, input, 1, which enables the parity bit.
REQ-009 SHALL have port parity_odd_i, input, 1, which selects odd parity (1) or even parity (0).
REQ-010 SHALL have port rx_data_o, output, 8, received byte, LSB-aligned, unused MSBs 0.
REQ-011 SHALL have port rx_valid_o, output, 1, held-data valid.
REQ-012 SHALL have port rx_ready_i, input, 1, consumer accept.
REQ-013 SHALL have ports parity_err_o and frame_err_o, output, 1 each, status of the held byte, qualified by rx_valid_o.
REQ-014 SHALL have port overrun_err_o, output, 1, one-cycle pulse.
REQ-015 SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchronizer; all following references to "line" mean the synchronized value.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: a line falling edge while enable_i=1 SHALL move the FSM to START and clear the internal oversample counter to 0.
REQ-019 The oversample counter SHALL increment only on osr_tick_i, wrap to 0 at OSR-1, and be $clog2(OSR) bits wide.
REQ-020 START: the line SHALL be sampled on the osr_tick_i taking the counter to OSR/2-1. If high, this is a false start: return to IDLE with no outputs changed. If low, clear the counter and go to DATA.
REQ-021 DATA/PARITY/STOP: each bit SHALL be sampled on the osr_tick_i taking the counter to OSR-1, i.e. at mid-bit.
REQ-022 DATA: bits SHALL be shifted in LSB first; after DATA_BITS samples go to PARITY if parity_en_i=1, else to STOP.
REQ-023 PARITY: parity_err SHALL be set when the XOR of the data bits and the parity bit differs from parity_odd_i.
REQ-024 STOP: frame_err SHALL be the inverse of the stop sample; the FSM SHALL return to IDLE on that same cycle so a following start edge is detected.
REQ-025 On the cycle after the stop sample, the byte and both error flags SHALL load into the output register and rx_valid_o SHALL rise, even when errors are present.
REQ-026 rx_valid_o SHALL stay high until the cycle after rx_valid_o && rx_ready_i.
REQ-027 If a byte completes while rx_valid_o=1 and rx_ready_i=0, the new byte SHALL be dropped, the held byte retained, and overrun_err_o pulsed for 1 cycle.
REQ-028 If completion coincides with rx_valid_o && rx_ready_i, the new byte SHALL load, rx_valid_o SHALL stay high, and there SHALL be no overrun.
REQ-029 enable_i=0 SHALL abort any in-flight frame (FSM to IDLE, counter 0) and leave the output register untouched.
REQ-030 parity_en_i and parity_odd_i SHALL be sampled at the START to DATA transition and held for the whole frame.

Reset
REQ-031 While reset_ni=0: FSM=IDLE, counter=0, synchronizer flops=1, rx_data_o=0, and rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o all 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for a fresh falling edge.

Configuration
REQ-033 With UART_RX_MAJORITY_EN defined, each sample SHALL be the 2-of-3 majority of line values captured at counter positions N-1, N and N+1 around the nominal sample point.
REQ-034 With UART_RX_MAJORITY_EN undefined, the single line value at the nominal point SHALL be used; all other behaviour is identical.

Structure
REQ-035 uart_pkg SHALL hold the rx_state_t enum and the limits DATA_BITS_MIN=5 and DATA_BITS_MAX=8.
REQ-036 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer and edge detector; the FSM, counter and output register SHALL stay in uart_rx.

Verification
REQ-037 OSR=16, osr_tick_i every 4 clocks, frame 0xA5 with no parity -> rx_data_o=0xA5, rx_valid_o=1, no error flags.
REQ-038 rx_i driven low for 3 oversample ticks then high -> busy_o pulses high, rx_valid_o never rises.
REQ-039 parity_en_i=1, parity_odd_i=0, data 0x03 with parity bit 1 -> rx_data_o=0x03, parity_err_o=1.
REQ-040 Frame 0x5A with stop bit 0 -> rx_data_o=0x5A, frame_err_o=1, and a following frame 0x11 is received correctly.
REQ-041 Frames 0x12 then 0x34 with rx_ready_i=0 -> overrun_err_o pulses once, rx_data_o stays 0x12.
REQ-042 reset_ni pulsed low after 4 data bits of 0xFF -> all outputs 0, and a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM state type, configuration limits and helpers.
package uart_pkg;

   localparam int unsigned DATA_BITS_MIN = 5;
   localparam int unsigned DATA_BITS_MAX = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   // 2-of-3 majority vote
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset to 1 so an idle-high line never produces a spurious edge.
module uart_rx_sync (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic rx_i,
   output logic line_o,
   output logic fall_o
);

   logic meta_q, meta_d;
   logic line_q, line_d;
   logic prev_q, prev_d;

   // Next-state for the synchronizer chain and the edge-detect history flop
   always_comb begin
      meta_d = rx_i;
      line_d = meta_q;
      prev_d = line_q;
   end

   // Synchronizer and edge-detect registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         meta_q <= 1'b1;
         line_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         line_q <= line_d;
         prev_q <= prev_d;
      end
   end

   assign line_o = line_q;
   assign fall_o = prev_q & ~line_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, DATA_BITS data LSB first,
// optional parity, one stop bit) with a ready/valid output register.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned OSR       = 16,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       enable_i,
   input  logic       osr_tick_i,
   input  logic       rx_i,
   input  logic       parity_en_i,
   input  logic       parity_odd_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       overrun_err_o,
   output logic       busy_o
);

   localparam int unsigned CW = $clog2(OSR);
   localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);

   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX || OSR < 8 || (OSR % 2) != 0) begin : g_bad_cfg
      $error("uart_rx: unsupported OSR/DATA_BITS configuration");
   end

   logic line, fall;

   uart_rx_sync u_sync (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .rx_i     (rx_i),
      .line_o   (line),
      .fall_o   (fall)
   );

   rx_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            par_acc_q, par_acc_d;
   logic            par_en_q, par_en_d;
   logic            par_odd_q, par_odd_d;
   logic            par_err_q, par_err_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;

   logic [CW-1:0]   cnt_inc;
   logic [CW-1:0]   cnt_after_start;
   logic            start_pt, bit_pt, samp, complete;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0]      hist_q, hist_d;

   // Line history on each oversample tick: [0] newest, [1] one tick older
   always_comb begin
      hist_d = hist_q;
      if (osr_tick_i) begin
         hist_d = {hist_q[0], line};
      end
   end

   // Majority history register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         hist_q <= '1;
      end else begin
         hist_q <= hist_d;
      end
   end

   // The vote needs the value at N+1, so each decision is taken one tick
   // after the nominal point; the counter restarts at 1 after the start
   // decision so every later bit keeps the nominal mid-bit alignment.
   always_comb begin
      cnt_inc         = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      start_pt        = osr_tick_i && (cnt_inc == CW'(OSR / 2));
      bit_pt          = osr_tick_i && (cnt_inc == '0);
      samp            = maj3(hist_q[1], hist_q[0], line);
      cnt_after_start = CW'(1);
   end
`else
   // Sample-point decode: single line value at the nominal point
   always_comb begin
      cnt_inc         = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      start_pt        = osr_tick_i && (cnt_inc == CW'(OSR / 2 - 1));
      bit_pt          = osr_tick_i && (cnt_inc == CNT_MAX);
      samp            = line;
      cnt_after_start = '0;
   end
`endif

   // Frame FSM next-state, bit assembly and output-register update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_acc_d = par_acc_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      par_err_d = par_err_q;
      data_d    = data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ovr_d     = 1'b0;
      complete  = 1'b0;

      if (valid_q && rx_ready_i) begin
         valid_d = 1'b0;
      end

      if (state_q != ST_IDLE && osr_tick_i) begin
         cnt_d = cnt_inc;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable_i && fall) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (start_pt) begin
               if (samp) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d   = ST_DATA;
                  cnt_d     = cnt_after_start;
                  bit_cnt_d = '0;
                  par_acc_d = 1'b0;
                  par_err_d = 1'b0;
                  par_en_d  = parity_en_i;
                  par_odd_d = parity_odd_i;
               end
            end
         end
         ST_DATA: begin
            if (bit_pt) begin
               shreg_d   = {samp, shreg_q[7:1]};
               par_acc_d = par_acc_q ^ samp;
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_pt) begin
               par_err_d = (par_acc_q ^ samp) != par_odd_q;
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_pt) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               complete = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (!enable_i) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         complete = 1'b0;
      end

      if (complete) begin
         if (valid_q && !rx_ready_i) begin
            ovr_d = 1'b1;
         end else begin
            data_d  = shreg_q >> (DATA_BITS_MAX - DATA_BITS);
            perr_d  = par_err_q;
            ferr_d  = ~samp;
            valid_d = 1'b1;
         end
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         par_acc_q <= 1'b0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         par_err_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_acc_q <= par_acc_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         par_err_q <= par_err_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign rx_data_o     = data_q;
   assign rx_valid_o    = valid_q;
   assign parity_err_o  = perr_q;
   assign frame_err_o   = ferr_q;
   assign overrun_err_o = ovr_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (OSR=16, DATA_BITS=8, tick every 4 clocks).
module tb_uart_rx;

   localparam int unsigned OSR      = 16;
   localparam int unsigned TICK_DIV = 4;

   logic       clk          = 1'b0;
   logic       reset_ni     = 1'b0;
   logic       enable_i     = 1'b0;
   logic       osr_tick_i   = 1'b0;
   logic       rx_i         = 1'b1;
   logic       parity_en_i  = 1'b0;
   logic       parity_odd_i = 1'b0;
   logic       rx_ready_i   = 1'b0;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o;

   int unsigned npass   = 0;
   int unsigned ntotal  = 0;
   int unsigned ovr_cnt = 0;

   typedef struct {
      string      name;
      logic [7:0] data;
      bit         pen, podd, pbit, stop;
      logic [7:0] exp_data;
      bit         exp_perr, exp_ferr;
   } vec_t;

   vec_t vecs[10];

   uart_rx #(.OSR(OSR), .DATA_BITS(8)) dut (
      .clk_i         (clk),
      .reset_ni      (reset_ni),
      .enable_i      (enable_i),
      .osr_tick_i    (osr_tick_i),
      .rx_i          (rx_i),
      .parity_en_i   (parity_en_i),
      .parity_odd_i  (parity_odd_i),
      .rx_data_o     (rx_data_o),
      .rx_valid_o    (rx_valid_o),
      .rx_ready_i    (rx_ready_i),
      .parity_err_o  (parity_err_o),
      .frame_err_o   (frame_err_o),
      .overrun_err_o (overrun_err_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         osr_tick_i = 1'b1;
         @(negedge clk);
         osr_tick_i = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (overrun_err_o) ovr_cnt <= ovr_cnt + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic hold_bits(input logic v, input int unsigned nbits);
      rx_i = v;
      repeat (nbits * OSR * TICK_DIV) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                             input bit pbit, input bit stop);
      parity_en_i  = pen;
      parity_odd_i = podd;
      hold_bits(1'b1, 2);
      hold_bits(1'b0, 1);
      for (int i = 0; i < 8; i++) hold_bits(d[i], 1);
      if (pen) hold_bits(pbit, 1);
      hold_bits(stop, 1);
      hold_bits(1'b1, 2);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] ed, input bit ep, input bit ef);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (rx_valid_o) ok = 1'b1;
         else @(negedge clk);
      end
      check({tag, "_valid"}, 32'(ok), 32'd1);
      check({tag, "_data"}, 32'(rx_data_o), 32'(ed));
      check({tag, "_perr"}, 32'(parity_err_o), 32'(ep));
      check({tag, "_ferr"}, 32'(frame_err_o), 32'(ef));
   endtask

   task automatic consume(input string tag);
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
      check({tag, "_consumed"}, 32'(rx_valid_o), 32'd0);
   endtask

   // Reference model: expected flags derived from the frame's bit values
   function automatic bit model_perr(input logic [7:0] d, input bit pen, input bit podd, input bit pbit);
      if (!pen) return 1'b0;
      return ((($countones(d) + pbit) % 2) != podd);
   endfunction

   initial begin
      bit seen_busy, seen_valid;
      int unsigned ovr_before;
      logic [7:0] rd;
      bit rpen, rpodd, rpbit, rstop;

      vecs[0] = '{"a5_plain",   8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0};
      vecs[1] = '{"03_even_bad", 8'h03, 1, 0, 1, 1, 8'h03, 1, 0};
      vecs[2] = '{"5a_nostop",  8'h5A, 0, 0, 0, 0, 8'h5A, 0, 1};
      vecs[3] = '{"11_after",   8'h11, 0, 0, 0, 1, 8'h11, 0, 0};
      vecs[4] = '{"03_even_ok", 8'h03, 1, 0, 0, 1, 8'h03, 0, 0};
      vecs[5] = '{"07_odd_ok",  8'h07, 1, 1, 0, 1, 8'h07, 0, 0};
      vecs[6] = '{"00_odd_bad", 8'h00, 1, 1, 0, 1, 8'h00, 1, 0};
      vecs[7] = '{"ff_both",    8'hFF, 1, 0, 1, 0, 8'hFF, 1, 1};
      vecs[8] = '{"80_msb",     8'h80, 0, 0, 0, 1, 8'h80, 0, 0};
      vecs[9] = '{"01_lsb",     8'h01, 0, 1, 0, 1, 8'h01, 0, 0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", 32'(rx_data_o), 32'd0);
      check("rst_valid", 32'(rx_valid_o), 32'd0);
      check("rst_perr", 32'(parity_err_o), 32'd0);
      check("rst_ferr", 32'(frame_err_o), 32'd0);
      check("rst_ovr", 32'(overrun_err_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      reset_ni = 1'b1;
      enable_i = 1'b1;

      // Directed frame table
      foreach (vecs[k]) begin
         send_frame(vecs[k].data, vecs[k].pen, vecs[k].podd, vecs[k].pbit, vecs[k].stop);
         expect_byte(vecs[k].name, vecs[k].exp_data, vecs[k].exp_perr, vecs[k].exp_ferr);
         consume(vecs[k].name);
      end

      // Randomised frames against the reference model
      for (int n = 0; n < 12; n++) begin
         rd    = 8'($urandom_range(0, 255));
         rpen  = 1'($urandom_range(0, 1));
         rpodd = 1'($urandom_range(0, 1));
         rpbit = 1'($urandom_range(0, 1));
         rstop = ($urandom_range(0, 3) != 0);
         send_frame(rd, rpen, rpodd, rpbit, rstop);
         expect_byte($sformatf("rand%0d", n), rd, model_perr(rd, rpen, rpodd, rpbit), !rstop);
         consume($sformatf("rand%0d", n));
      end

      // False start: line low for 3 ticks only
      hold_bits(1'b1, 2);
      seen_busy  = 1'b0;
      seen_valid = 1'b0;
      rx_i = 1'b0;
      repeat (3 * TICK_DIV) @(negedge clk);
      rx_i = 1'b1;
      for (int i = 0; i < 60 * TICK_DIV; i++) begin
         @(negedge clk);
         seen_busy  |= busy_o;
         seen_valid |= rx_valid_o;
      end
      check("false_busy_seen", 32'(seen_busy), 32'd1);
      check("false_valid_seen", 32'(seen_valid), 32'd0);
      check("false_busy_end", 32'(busy_o), 32'd0);

      // Enable dropped mid-frame aborts it without touching outputs
      parity_en_i = 1'b0;
      hold_bits(1'b1, 2);
      hold_bits(1'b0, 4);
      check("abort_busy_before", 32'(busy_o), 32'd1);
      enable_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_busy_after", 32'(busy_o), 32'd0);
      hold_bits(1'b0, 5);
      hold_bits(1'b1, 3);
      check("abort_valid", 32'(rx_valid_o), 32'd0);
      enable_i = 1'b1;

      // Overrun: two frames without consuming
      ovr_before = ovr_cnt;
      send_frame(8'h12, 0, 0, 0, 1);
      send_frame(8'h34, 0, 0, 0, 1);
      check("ovr_pulses", ovr_cnt - ovr_before, 32'd1);
      check("ovr_data_kept", 32'(rx_data_o), 32'h12);
      check("ovr_valid_kept", 32'(rx_valid_o), 32'd1);

      // Reset mid-frame after 4 data bits of 0xFF, with 0x12 still held
      hold_bits(1'b1, 2);
      hold_bits(1'b0, 1);
      for (int i = 0; i < 4; i++) hold_bits(1'b1, 1);
      check("midrst_busy_before", 32'(busy_o), 32'd1);
      reset_ni = 1'b0;
      @(negedge clk);
      check("midrst_data", 32'(rx_data_o), 32'd0);
      check("midrst_valid", 32'(rx_valid_o), 32'd0);
      check("midrst_perr", 32'(parity_err_o), 32'd0);
      check("midrst_ferr", 32'(frame_err_o), 32'd0);
      check("midrst_ovr", 32'(overrun_err_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      repeat (4) @(negedge clk);
      reset_ni = 1'b1;
      hold_bits(1'b1, 6);
      check("postrst_busy", 32'(busy_o), 32'd0);
      check("postrst_valid", 32'(rx_valid_o), 32'd0);
      send_frame(8'h81, 0, 0, 0, 1);
      expect_byte("postrst_81", 8'h81, 1'b0, 1'b0);
      consume("postrst_81");

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
